// File: rtl/exe_dreq_ctrl_if.sv
// Data-SRAM request channel between the EXE-stage issuer (master) and the memory port (slave).
interface exe_dreq_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              data_sram_req;
  logic              data_sram_wr;
  logic [1:0]        data_sram_size;
  logic [3:0]        data_sram_wstrb;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [31:0]       data_sram_wdata;
  logic              data_sram_addr_ok;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok
  );
endinterface

// File: rtl/exe_dreq_ctrl.sv
// EXE-stage data request issuer: one SRAM-like request per load/store, ALE detection,
// ready_go control and the ls_cancel/mem_we flags forwarded to MEM.
module exe_dreq_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exe_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] vaddr,
  input  logic [31:0]       st_data,
  input  logic              mem_allow_in,
  input  logic              wb_ex,
  input  logic              ertn_flush,
  input  logic              mem_cancel,
  exe_dreq_ctrl_if.master   dbus,
  output logic              exe_ready_go,
  output logic              ale_ex,
  output logic              ls_cancel,
  output logic              mem_we
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              kill_sticky;
  logic              lat_en;
  logic              lat_wr;
  logic [1:0]        lat_size;
  logic [3:0]        lat_wstrb;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              ldst, kill_now, kill, issued, handover;
  logic [1:0]        sz_eff;
  logic              cur_wr;
  logic [3:0]        cur_wstrb;
  logic [31:0]       cur_wdata;

  logic              req, wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              addr_ok;

  assign addr_ok  = dbus.data_sram_addr_ok;
  assign ldst     = exe_valid & (is_load | is_store);
  assign sz_eff   = (ls_size == 2'd3) ? 2'd2 : ls_size;
  assign ale_ex   = ldst & (((sz_eff == 2'd1) & vaddr[0]) |
                            ((sz_eff == 2'd2) & (vaddr[1:0] != 2'b00)));
  assign kill_now = wb_ex | ertn_flush | mem_cancel;
  assign kill     = kill_now | kill_sticky;
  assign cur_wr   = ldst & is_store;

  // Lane enables and replicated store data for the current instruction
  always_comb begin
    cur_wstrb = 4'b0000;
    cur_wdata = 32'h0;
    case (sz_eff)
      2'd0: begin
        cur_wstrb = 4'b0001 << vaddr[1:0];
        cur_wdata = {4{st_data[7:0]}};
      end
      2'd1: begin
        cur_wstrb = vaddr[1] ? 4'b1100 : 4'b0011;
        cur_wdata = {2{st_data[15:0]}};
      end
      default: begin
        cur_wstrb = 4'b1111;
        cur_wdata = st_data;
      end
    endcase
    if (!cur_wr) begin
      cur_wstrb = 4'b0000;
      cur_wdata = 32'h0;
    end
  end

  // Next state and request channel drive
  always_comb begin
    state_nxt = state;
    lat_en    = 1'b0;
    req       = 1'b0;
    wr        = 1'b0;
    size      = 2'd0;
    wstrb     = 4'b0000;
    addr      = '0;
    wdata     = 32'h0;
    case (state)
      S_IDLE: begin
        req   = ldst & ~ale_ex & ~kill;
        wr    = cur_wr;
        size  = sz_eff;
        wstrb = cur_wstrb;
        addr  = vaddr;
        wdata = cur_wdata;
        if (req & ~addr_ok) begin
          state_nxt = S_WAIT;
          lat_en    = 1'b1;
        end else if (req & addr_ok & ~mem_allow_in) begin
          state_nxt = S_ACC;
        end
      end
      S_WAIT: begin
        req   = 1'b1;
        wr    = lat_wr;
        size  = lat_size;
        wstrb = lat_wstrb;
        addr  = lat_addr;
        wdata = lat_wdata;
        if (addr_ok) state_nxt = mem_allow_in ? S_IDLE : S_ACC;
      end
      S_ACC: begin
        if (mem_allow_in) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign issued       = (state != S_IDLE) | (req & addr_ok);
  assign exe_ready_go = ~ldst | ale_ex | (kill & ~issued & (state == S_IDLE)) |
                        (req & addr_ok) | (state == S_ACC);
  assign ls_cancel    = ldst & (ale_ex | kill) & ~issued;
  assign mem_we       = exe_valid & is_store;
  assign handover     = exe_valid & exe_ready_go & mem_allow_in;

  assign dbus.data_sram_req   = req;
  assign dbus.data_sram_wr    = wr;
  assign dbus.data_sram_size  = size;
  assign dbus.data_sram_wstrb = wstrb;
  assign dbus.data_sram_addr  = addr;
  assign dbus.data_sram_wdata = wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Flush seen while the instruction sits in EXE; set wins over clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     kill_sticky <= 1'b0;
    else if (exe_valid & kill_now)   kill_sticky <= 1'b1;
    else if (handover | ~exe_valid)  kill_sticky <= 1'b0;
  end

  // Request fields frozen while waiting for addr_ok
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_wr    <= 1'b0;
      lat_size  <= 2'd0;
      lat_wstrb <= 4'b0000;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
    end else if (lat_en) begin
      lat_wr    <= cur_wr;
      lat_size  <= sz_eff;
      lat_wstrb <= cur_wstrb;
      lat_addr  <= vaddr;
      lat_wdata <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_exe_dreq_ctrl.sv
// Directed bench for exe_dreq_ctrl: transaction-level reference model checked every
// cycle, plus literal expectations at the scenario points.
module tb_exe_dreq_ctrl;

  logic        clk;
  logic        resetn;
  logic        exe_valid, is_load, is_store;
  logic [1:0]  ls_size;
  logic [31:0] vaddr, st_data;
  logic        mem_allow_in, wb_ex, ertn_flush, mem_cancel;
  logic        exe_ready_go, ale_ex, ls_cancel, mem_we;

  int vectors = 0;
  int errs    = 0;

  exe_dreq_ctrl_if #(.ADDR_W(32)) dbus ();

  exe_dreq_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .exe_valid    (exe_valid),
    .is_load      (is_load),
    .is_store     (is_store),
    .ls_size      (ls_size),
    .vaddr        (vaddr),
    .st_data      (st_data),
    .mem_allow_in (mem_allow_in),
    .wb_ex        (wb_ex),
    .ertn_flush   (ertn_flush),
    .mem_cancel   (mem_cancel),
    .dbus         (dbus),
    .exe_ready_go (exe_ready_go),
    .ale_ex       (ale_ex),
    .ls_cancel    (ls_cancel),
    .mem_we       (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } rq_t;

  // Reference model: one instruction in flight, tracked as pending / accepted
  bit  m_pend, m_acc, m_ks;
  rq_t m_rec, cur, exp_rq;

  always @(negedge clk) begin
    int  n;
    bit  ld_st, ale, kn, kl, aok, e_req, e_iss, e_rdy, e_can, hand;
    if (!resetn) begin
      m_pend = 0; m_acc = 0; m_ks = 0;
    end
    n     = (ls_size == 2'd0) ? 1 : (ls_size == 2'd1) ? 2 : 4;
    ld_st = exe_valid && (is_load || is_store);
    ale   = ld_st && ((vaddr % 32'(n)) != 0);
    kn    = wb_ex || ertn_flush || mem_cancel;
    kl    = kn || m_ks;
    aok   = dbus.data_sram_addr_ok;

    cur.addr  = vaddr;
    cur.size  = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    cur.wr    = is_store;
    cur.wstrb = is_store ? 4'(((1 << n) - 1) << (vaddr & 32'(4 - n))) : 4'b0000;
    cur.wdata = !is_store ? 32'h0 :
                (n == 1) ? 32'(st_data[7:0]) * 32'h0101_0101 :
                (n == 2) ? 32'(st_data[15:0]) * 32'h0001_0001 : st_data;

    if (m_acc)       begin e_req = 0; exp_rq = cur;   end
    else if (m_pend) begin e_req = 1; exp_rq = m_rec; end
    else             begin e_req = ld_st && !ale && !kl; exp_rq = cur; end
    e_iss = m_acc || m_pend || (e_req && aok);
    e_rdy = !ld_st || ale || (kl && !e_iss) || (e_req && aok) || m_acc;
    e_can = ld_st && (ale || kl) && !e_iss;

    chk("m_req",    32'(dbus.data_sram_req), 32'(e_req));
    chk("m_ready",  32'(exe_ready_go),       32'(e_rdy));
    chk("m_ale",    32'(ale_ex),             32'(ale));
    chk("m_cancel", 32'(ls_cancel),          32'(e_can));
    chk("m_we",     32'(mem_we),             32'(exe_valid && is_store));
    if (e_req) begin
      chk("m_addr",  dbus.data_sram_addr,          exp_rq.addr);
      chk("m_size",  32'(dbus.data_sram_size),     32'(exp_rq.size));
      chk("m_wr",    32'(dbus.data_sram_wr),       32'(exp_rq.wr));
      chk("m_wstrb", 32'(dbus.data_sram_wstrb),    32'(exp_rq.wstrb));
      if (exp_rq.wr) chk("m_wdata", dbus.data_sram_wdata, exp_rq.wdata);
    end

    if (resetn) begin
      hand = exe_valid && e_rdy && mem_allow_in;
      if (exe_valid && kn)          m_ks = 1;
      else if (hand || !exe_valid)  m_ks = 0;
      if (m_acc) begin
        if (mem_allow_in) m_acc = 0;
      end else if (m_pend) begin
        if (aok) begin m_pend = 0; m_acc = !mem_allow_in; end
      end else if (e_req) begin
        if (aok) m_acc = !mem_allow_in;
        else begin m_pend = 1; m_rec = cur; end
      end
    end
  end

  task automatic drv(input bit v, input bit ld, input bit st, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d, input bit allow, input bit aok);
    exe_valid = v; is_load = ld; is_store = st; ls_size = sz;
    vaddr = a; st_data = d; mem_allow_in = allow;
    dbus.data_sram_addr_ok = aok;
  endtask

  task automatic idle();
    drv(0, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0);
    wb_ex = 0; ertn_flush = 0; mem_cancel = 0;
  endtask

  task automatic at_neg(); @(negedge clk); #1; endtask
  task automatic at_pos(); @(posedge clk); #1; endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    idle();
    at_neg();
    chk("rst_req",    32'(dbus.data_sram_req),   32'd0);
    chk("rst_ready",  32'(exe_ready_go),         32'd1);
    chk("rst_cancel", 32'(ls_cancel),            32'd0);
    chk("rst_wstrb",  32'(dbus.data_sram_wstrb), 32'd0);
    chk("rst_we",     32'(mem_we),               32'd0);
    at_pos(); resetn = 1;
    at_pos();

    // st.w accepted and handed over in one cycle
    drv(1, 0, 1, 2'd2, 32'h1C, 32'hAABBCCDD, 1, 1);
    at_neg();
    chk("stw_req",    32'(dbus.data_sram_req),   32'd1);
    chk("stw_wr",     32'(dbus.data_sram_wr),    32'd1);
    chk("stw_wstrb",  32'(dbus.data_sram_wstrb), 32'hF);
    chk("stw_wdata",  dbus.data_sram_wdata,      32'hAABBCCDD);
    chk("stw_ready",  32'(exe_ready_go),         32'd1);
    chk("stw_cancel", 32'(ls_cancel),            32'd0);
    at_pos();

    // st.b top lane
    drv(1, 0, 1, 2'd0, 32'h1003, 32'h5A, 1, 1);
    at_neg();
    chk("stb_wstrb", 32'(dbus.data_sram_wstrb), 32'h8);
    chk("stb_wdata", dbus.data_sram_wdata,      32'h5A5A5A5A);
    chk("stb_size",  32'(dbus.data_sram_size),  32'd0);
    at_pos();

    // st.h upper half
    drv(1, 0, 1, 2'd1, 32'h6, 32'hFFFF1234, 1, 1);
    at_neg();
    chk("sth_wstrb", 32'(dbus.data_sram_wstrb), 32'hC);
    chk("sth_wdata", dbus.data_sram_wdata,      32'h12341234);
    at_pos();

    // illegal size 3 behaves as word
    drv(1, 0, 1, 2'd3, 32'h8, 32'h01020304, 1, 1);
    at_neg();
    chk("sz3_size",  32'(dbus.data_sram_size),  32'd2);
    chk("sz3_wstrb", 32'(dbus.data_sram_wstrb), 32'hF);
    at_pos();

    // ld.h misaligned
    drv(1, 1, 0, 2'd1, 32'h2001, 32'h0, 1, 0);
    at_neg();
    chk("ale_ale",    32'(ale_ex),              32'd1);
    chk("ale_req",    32'(dbus.data_sram_req),  32'd0);
    chk("ale_cancel", 32'(ls_cancel),           32'd1);
    chk("ale_ready",  32'(exe_ready_go),        32'd1);
    at_pos();

    // ld.w waiting 3 cycles; address stays latched when vaddr moves
    drv(1, 1, 0, 2'd2, 32'h40, 32'h0, 1, 0);
    at_neg();
    chk("wait1_req",   32'(dbus.data_sram_req), 32'd1);
    chk("wait1_ready", 32'(exe_ready_go),       32'd0);
    at_pos(); vaddr = 32'h80;
    at_neg();
    chk("wait2_addr",  dbus.data_sram_addr,     32'h40);
    chk("wait2_ready", 32'(exe_ready_go),       32'd0);
    at_pos();
    at_neg();
    chk("wait3_req",   32'(dbus.data_sram_req), 32'd1);
    at_pos(); dbus.data_sram_addr_ok = 1;
    at_neg();
    chk("wait4_req",   32'(dbus.data_sram_req), 32'd1);
    chk("wait4_addr",  dbus.data_sram_addr,     32'h40);
    chk("wait4_ready", 32'(exe_ready_go),       32'd1);
    at_pos(); idle();
    at_pos();

    // flush while a request is outstanding: request is held and completes
    drv(1, 1, 0, 2'd2, 32'h44, 32'h0, 1, 0);
    at_pos(); wb_ex = 1;
    at_neg();
    chk("wflush_req",    32'(dbus.data_sram_req), 32'd1);
    chk("wflush_cancel", 32'(ls_cancel),          32'd0);
    at_pos(); wb_ex = 0;
    at_neg();
    chk("wflush_ready",  32'(exe_ready_go),       32'd0);
    at_pos(); dbus.data_sram_addr_ok = 1;
    at_neg();
    chk("wflush_acc_req",    32'(dbus.data_sram_req), 32'd1);
    chk("wflush_acc_cancel", 32'(ls_cancel),          32'd0);
    at_pos(); idle();
    at_pos();

    // flush before any request: cancelled, never issued
    drv(1, 1, 0, 2'd2, 32'h44, 32'h0, 1, 0);
    wb_ex = 1;
    at_neg();
    chk("iflush_req",    32'(dbus.data_sram_req), 32'd0);
    chk("iflush_cancel", 32'(ls_cancel),          32'd1);
    chk("iflush_ready",  32'(exe_ready_go),       32'd1);
    at_pos(); idle();
    at_pos();

    // ertn and mem_cancel also suppress the request
    drv(1, 0, 1, 2'd1, 32'h2002, 32'h77, 1, 1);
    ertn_flush = 1;
    at_neg();
    chk("ertn_cancel", 32'(ls_cancel), 32'd1);
    at_pos(); ertn_flush = 0;
    drv(1, 1, 0, 2'd0, 32'h7, 32'h0, 1, 1);
    mem_cancel = 1;
    at_neg();
    chk("mcan_req", 32'(dbus.data_sram_req), 32'd0);
    at_pos(); idle();
    at_pos();

    // accepted while MEM is blocked: no second request
    drv(1, 1, 0, 2'd0, 32'h3, 32'h0, 0, 1);
    at_neg();
    chk("acc1_req",   32'(dbus.data_sram_req), 32'd1);
    chk("acc1_ready", 32'(exe_ready_go),       32'd1);
    at_pos();
    at_neg();
    chk("acc2_req",   32'(dbus.data_sram_req), 32'd0);
    chk("acc2_ready", 32'(exe_ready_go),       32'd1);
    at_pos(); mem_allow_in = 1;
    at_neg();
    chk("acc3_req",   32'(dbus.data_sram_req), 32'd0);
    at_pos(); idle();
    at_pos();

    // asynchronous reset in WAIT
    drv(1, 1, 0, 2'd2, 32'h50, 32'h0, 1, 0);
    at_pos();
    chk("arst_pre_req", 32'(dbus.data_sram_req), 32'd1);
    #2 resetn = 0; exe_valid = 0;
    #1;
    chk("arst_req", 32'(dbus.data_sram_req), 32'd0);
    at_pos(); resetn = 1;
    at_neg();
    chk("arst_ready", 32'(exe_ready_go), 32'd1);
    at_pos();
    drv(1, 1, 0, 2'd2, 32'h50, 32'h0, 1, 1);
    at_neg();
    chk("arst_idle_req",   32'(dbus.data_sram_req), 32'd1);
    chk("arst_idle_ready", 32'(exe_ready_go),       32'd1);
    at_pos(); idle();
    at_pos();
    at_pos();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/exe_dreq_ctrl.md
Name: exe_dreq_ctrl

Overview:
- Data-memory request issuer in the EXE stage, directly upstream of MEM.
- Converts the EXE-stage load/store into a single SRAM-like data request (req/addr_ok handshake).
- Detects address-misalignment (ALE) and controls EXE ready_go.
- Generates the ls_cancel and mem_we flags that travel on the EXE-to-MEM bus, so MEM knows whether to wait for data_ok.

Parameters:
- ADDR_W, 32, data address width (data width fixed at 32).

Ports:
- clk  in  1  clock
- resetn  in  1  reset (asynchronous, active-low)
- exe_valid  in  1  EXE stage holds a valid instruction
- is_load  in  1  instruction is ld.b/h/bu/hu/w
- is_store  in  1  instruction is st.b/h/w
- ls_size  in  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
- vaddr  in  ADDR_W  effective address (ALU result)
- st_data  in  32  rk register value for stores
- mem_allow_in  in  1  MEM can accept this cycle
- wb_ex  in  1  exception flush from WB
- ertn_flush  in  1  ertn flush from WB
- mem_cancel  in  1  MEM holds exception/ertn (MEM's ldst_cancel)
- data_sram_addr_ok  in  1  request accepted by memory
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1=store
- data_sram_size  out  2  byte/half/word
- data_sram_wstrb  out  4  byte enables
- data_sram_addr  out  ADDR_W  request address
- data_sram_wdata  out  32  store data, lane-replicated
- exe_ready_go  out  1  EXE may hand over to MEM
- ale_ex  out  1  misaligned-address exception for this instruction
- ls_cancel  out  1  load/store cancelled, never issued; MEM must not wait for data_ok
- mem_we  out  1  instruction is a store (bus flag)

Behaviour:
- Signal definitions:
  - ldst = exe_valid & (is_load | is_store)
  - ale_ex = ldst & ((size==half & vaddr[0]) | (size==word & vaddr[1:0]!=0)); combinational
  - kill_now = wb_ex | ertn_flush | mem_cancel
  - kill = kill_now | kill_sticky
  - handover = exe_valid & exe_ready_go & mem_allow_in
- kill_sticky (register):
  - set when exe_valid & kill_now
  - cleared on handover or when ~exe_valid
  - set has priority over clear in the same cycle
- FSM states: IDLE, WAIT (req outstanding), ACC (accepted, awaiting MEM).
- IDLE:
  - data_sram_req = ldst & ~ale_ex & ~kill
  - address, size, wr, wstrb and wdata are driven combinationally from the inputs
  - on req & ~addr_ok: latch addr/size/wr/wstrb/wdata, go to WAIT
  - on req & addr_ok & ~mem_allow_in: go to ACC
  - on req & addr_ok & mem_allow_in: stay IDLE
- WAIT:
  - req = 1 with latched fields; once asserted, req is never dropped, even on kill
  - on addr_ok: go to IDLE if mem_allow_in, else ACC
- ACC:
  - req = 0
  - on mem_allow_in: go to IDLE
- issued = (state!=IDLE) | (data_sram_req & addr_ok)
- exe_ready_go = ~ldst | ale_ex | (kill & ~issued & state==IDLE) | (req & addr_ok) | state==ACC
- ls_cancel = ldst & (ale_ex | kill) & ~issued
  - An accepted request is never cancelled; MEM drains its data_ok.
- mem_we = exe_valid & is_store
- Write strobes (stores only; loads drive 0000):
  - byte: 4'b0001 << vaddr[1:0]
  - half: vaddr[1] ? 1100 : 0011
  - word: 1111
- Write data:
  - byte: {4{st_data[7:0]}}
  - half: {2{st_data[15:0]}}
  - word: st_data
- data_sram_addr is the full vaddr, unmodified.
- At most one request is outstanding from this block; no new req in WAIT or ACC.
- Reset (asynchronous): state=IDLE, kill_sticky=0, latches=0. With exe_valid=0, all outputs are 0 except exe_ready_go=1.
- Reset mid-WAIT: req drops immediately and the FSM returns to IDLE.

Test Plan:
- st.w at addr 0x1C, data 0xAABBCCDD, addr_ok same cycle, mem_allow_in=1:
  - req=1, wr=1, wstrb=1111, wdata=0xAABBCCDD, ready_go=1 in the same cycle, ls_cancel=0
- st.b at 0x1003, data 0x5A:
  - wstrb=1000, wdata=0x5A5A5A5A, size=0
- ld.h at 0x2001:
  - ale_ex=1, req=0, ls_cancel=1, ready_go=1
- ld.w at 0x40, addr_ok held low 3 cycles, vaddr input changed in cycle 2:
  - req held 4 cycles with addr stable at 0x40 (latched), ready_go=0 until addr_ok
- ld.w in WAIT, wb_ex pulsed, then addr_ok:
  - req held, ls_cancel=0 after acceptance
- Same ld.w with wb_ex pulsed in IDLE before any req:
  - req=0, ls_cancel=1, ready_go=1
- ld.b, addr_ok=1 while mem_allow_in=0 for 2 cycles:
  - state ACC, req=0 with no second request, ready_go=1
  - handover on mem_allow_in, then IDLE
- resetn deasserted asynchronously during WAIT:
  - req falls before the next clk edge; after release, state=IDLE
